sdram_port_arbiter: RTL and testbench

//  Shares port 0 of the sdram controller between NUM_CLIENTS requesters.

---
 rtl/sdram_arb_pkg.sv | 28 ++
 rtl/sdram_port_arbiter_rr.sv | 33 +++
 rtl/sdram_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizes for the sdram port-0 arbiter.
package sdram_arb_pkg;

  localparam int DEF_NUM_CLIENTS = 3;
  localparam int DEF_ADDR_W      = 25;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_Q_W         = 128;
  localparam int DEF_REQ_HOLD    = 2;
  localparam int BURST_LEN       = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  // Bits needed to index n items; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr.sv
// Combinational round-robin pick: first requester after the pointer wins.
module rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N  = DEF_NUM_CLIENTS,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_cand;

  // Walk ptr+1, ptr+2, ... (mod N) and stop at the first active request.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IW'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares sdram controller port 0 among several clients, one transaction at a time.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int Q_W         = DEF_Q_W,
  parameter int REQ_HOLD    = DEF_REQ_HOLD
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_init_complete,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] i_c_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] i_c_data,
  input  logic [NUM_CLIENTS*2-1:0]      i_c_byte_en,
  input  logic [NUM_CLIENTS-1:0]        i_c_wr_req,
  input  logic [NUM_CLIENTS-1:0]        i_c_rd_req,
  output logic [NUM_CLIENTS-1:0]        o_c_ack,
  output logic [NUM_CLIENTS-1:0]        o_c_done,
  output logic [Q_W-1:0]                o_c_q,
  output logic [ADDR_W-1:0]             o_p0_addr,
  output logic [DATA_W-1:0]             o_p0_data,
  output logic [1:0]                    o_p0_byte_en,
  output logic                          o_p0_wr_req,
  output logic                          o_p0_rd_req,
  input  logic [Q_W-1:0]                i_p0_q,
  input  logic                          i_p0_ready,
  input  logic                          i_p0_available
);

  localparam int IDX_W = idx_width(NUM_CLIENTS);
  localparam int CNT_W = idx_width(REQ_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(REQ_HOLD - 1);

  arb_state_t               r_state;
  logic [IDX_W-1:0]         r_ptr;
  logic [IDX_W-1:0]         r_gidx;
  op_t                      r_op;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_captured;
  logic [NUM_CLIENTS-1:0]   r_done;
  logic [Q_W-1:0]           r_q;
  logic [ADDR_W-1:0]        r_p0_addr;
  logic [DATA_W-1:0]        r_p0_data;
  logic [1:0]               r_p0_be;
  logic                     r_p0_wr;
  logic                     r_p0_rd;

  logic [NUM_CLIENTS-1:0]   w_req;
  logic [NUM_CLIENTS-1:0]   w_grant;
  logic [IDX_W-1:0]         w_idx;
  logic                     w_any;
  logic                     w_start;
  logic [ADDR_W-1:0]        w_sel_addr;
  logic [DATA_W-1:0]        w_sel_data;
  logic [1:0]               w_sel_be;
  op_t                      w_sel_op;
  logic                     w_rd_hit;
  logic                     w_finish;

  assign w_req = i_c_wr_req | i_c_rd_req;

  rr_arbiter #(
    .N  (NUM_CLIENTS),
    .IW (IDX_W)
  ) u_rr (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // A grant starts only from a quiet IDLE; the cycle carrying c_done is skipped
  // so a new grant never lands on top of the previous completion pulse.
  assign w_start = !i_reset && (r_state == IDLE) && i_init_complete &&
                   i_p0_ready && w_any && (r_done == '0);

  // The ack is decided in the IDLE cycle itself so the client can drop its
  // request on the very edge that latches it.
  assign o_c_ack = w_start ? w_grant : '0;

  assign w_sel_addr = i_c_addr[int'(w_idx)*ADDR_W +: ADDR_W];
  assign w_sel_data = i_c_data[int'(w_idx)*DATA_W +: DATA_W];
  assign w_sel_be   = i_c_byte_en[int'(w_idx)*2 +: 2];
  assign w_sel_op   = i_c_wr_req[w_idx] ? OP_WR : OP_RD;

  // Read data may arrive on the same edge that ready returns.
  assign w_rd_hit = (r_op == OP_RD) && i_p0_available && !r_captured;
  assign w_finish = i_p0_ready && ((r_op == OP_WR) || r_captured || i_p0_available);

  // Main transaction sequencer: grant, replay request, wait busy, wait done.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_ptr      <= IDX_W'(NUM_CLIENTS - 1);
      r_gidx     <= '0;
      r_op       <= OP_RD;
      r_cnt      <= '0;
      r_captured <= 1'b0;
      r_done     <= '0;
      r_q        <= '0;
      r_p0_addr  <= '0;
      r_p0_data  <= '0;
      r_p0_be    <= '0;
      r_p0_wr    <= 1'b0;
      r_p0_rd    <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_ptr      <= w_idx;
            r_gidx     <= w_idx;
            r_op       <= w_sel_op;
            r_cnt      <= '0;
            r_captured <= 1'b0;
            r_p0_addr  <= w_sel_addr;
            r_p0_data  <= w_sel_data;
            r_p0_be    <= w_sel_be;
            r_p0_wr    <= (w_sel_op == OP_WR);
            r_p0_rd    <= (w_sel_op == OP_RD);
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_cnt == HOLD_LAST) begin
            r_p0_addr <= '0;
            r_p0_data <= '0;
            r_p0_be   <= '0;
            r_p0_wr   <= 1'b0;
            r_p0_rd   <= 1'b0;
            r_state   <= WAIT_BUSY;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_BUSY: begin
          if (!i_p0_ready) begin
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (w_rd_hit) begin
            r_q        <= i_p0_q;
            r_captured <= 1'b1;
          end
          if (w_finish) begin
            r_done  <= NUM_CLIENTS'(1) << r_gidx;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_c_done     = r_done;
  assign o_c_q        = r_q;
  assign o_p0_addr    = r_p0_addr;
  assign o_p0_data    = r_p0_data;
  assign o_p0_byte_en = r_p0_be;
  assign o_p0_wr_req  = r_p0_wr;
  assign o_p0_rd_req  = r_p0_rd;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a small behavioural port-0 model.
module tb_sdram_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int QW = 128;
  localparam logic [QW-1:0] JUNK = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_5A5A_A5A5;
  localparam logic [QW-1:0] BURST_EXP = 128'h3210_7654_BA98_FEDC_DEF0_9ABC_5678_1234;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, initC;
  logic [N*AW-1:0] cAddr;
  logic [N*DW-1:0] cData;
  logic [N*2-1:0]  cBe;
  logic [N-1:0]    cWr, cRd, cAck, cDone;
  logic [QW-1:0]   cQ, p0Q;
  logic [AW-1:0]   p0Addr;
  logic [DW-1:0]   p0Data;
  logic [1:0]      p0Be;
  logic            p0Wr, p0Rd, p0Ready, p0Avail;

  sdram_port_arbiter #(
    .NUM_CLIENTS (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .Q_W         (QW),
    .REQ_HOLD    (2)
  ) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_init_complete (initC),
    .i_c_addr        (cAddr),
    .i_c_data        (cData),
    .i_c_byte_en     (cBe),
    .i_c_wr_req      (cWr),
    .i_c_rd_req      (cRd),
    .o_c_ack         (cAck),
    .o_c_done        (cDone),
    .o_c_q           (cQ),
    .o_p0_addr       (p0Addr),
    .o_p0_data       (p0Data),
    .o_p0_byte_en    (p0Be),
    .o_p0_wr_req     (p0Wr),
    .o_p0_rd_req     (p0Rd),
    .i_p0_q          (p0Q),
    .i_p0_ready      (p0Ready),
    .i_p0_available  (p0Avail)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int ackCount[N];
  int doneCount[N];
  bit ackSeen[N];
  int grantLog[64];
  int grantN = 0;
  int firstReqCyc, lastAckCyc, doneCyc;
  int wrCycles, rdCycles;
  bit reqActive;
  logic [AW-1:0] reqAddr;
  logic [DW-1:0] reqData;
  logic [1:0]    reqBe;
  logic [QW-1:0] qAtDone;

  int            reqLeft[N];
  bit            wantWr[N], wantRd[N];
  logic [AW-1:0] planAddr[N];
  logic [DW-1:0] planData[N];
  logic [1:0]    planBe[N];
  bit            rstReq, initReq;

  logic [DW-1:0] mem[64];
  bit            mBusy, mWr, availEarly;
  int            mCnt, mReadyCyc;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mData;
  logic [1:0]    mBe;
  bit            sSeen, sWr;
  logic [AW-1:0] sAddr;
  logic [DW-1:0] sData;
  logic [1:0]    sBe;

  int expOrder[6] = '{0, 1, 2, 0, 1, 2};
  logic [DW-1:0] words[8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                               16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};
  int d0[N];
  int gStart, target, budget, sumNow;

  task automatic checkOutput(input string tag, input logic [QW-1:0] obs, input logic [QW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [QW-1:0] burstAt(input logic [AW-1:0] a);
    logic [QW-1:0] r;
    int base;
    base = int'(a[5:3]) * 8;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*16 +: 16] = mem[base + k];
    return r;
  endfunction

  // Drive client inputs and the controller model just after the rising edge.
  task automatic applyStimulus();
    reset = rstReq;
    initC = initReq;
    for (int i = 0; i < N; i++) begin
      if (ackSeen[i]) begin
        ackSeen[i] = 1'b0;
        if (reqLeft[i] > 0) reqLeft[i]--;
      end
      cAddr[i*AW +: AW] = planAddr[i];
      cData[i*DW +: DW] = planData[i];
      cBe[i*2 +: 2]     = planBe[i];
      cWr[i] = (reqLeft[i] > 0) && wantWr[i];
      cRd[i] = (reqLeft[i] > 0) && wantRd[i];
    end
    p0Avail = 1'b0;
    p0Q     = JUNK;
    if (mBusy) begin
      mCnt--;
      if (mCnt == 1 && availEarly && !mWr) begin
        p0Avail = 1'b1;
        p0Q     = burstAt(mAddr);
      end
      if (mCnt == 0) begin
        mBusy     = 1'b0;
        p0Ready   = 1'b1;
        mReadyCyc = cyc + 1;
        if (mWr) begin
          if (mBe[0]) mem[mAddr[5:0]][7:0]  = mData[7:0];
          if (mBe[1]) mem[mAddr[5:0]][15:8] = mData[15:8];
        end else if (!availEarly) begin
          p0Avail = 1'b1;
          p0Q     = burstAt(mAddr);
        end
      end
    end else if (sSeen && p0Ready) begin
      mBusy   = 1'b1;
      mCnt    = 6;
      p0Ready = 1'b0;
      mWr     = sWr;
      mAddr   = sAddr;
      mData   = sData;
      mBe     = sBe;
    end
  endtask

  // Mid-cycle observation of every DUT output.
  task automatic sampleOutputs();
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (cAck[i]) begin
        ackCount[i]++;
        ackSeen[i] = 1'b1;
        lastAckCyc = cyc;
        if (grantN < 64) begin
          grantLog[grantN] = i;
          grantN++;
        end
      end
      if (cDone[i]) begin
        doneCount[i]++;
        doneCyc = cyc;
        qAtDone = cQ;
      end
    end
    if (p0Wr || p0Rd) begin
      if (!reqActive) begin
        firstReqCyc = cyc;
        reqAddr = p0Addr;
        reqData = p0Data;
        reqBe   = p0Be;
      end
      reqActive = 1'b1;
      if (p0Wr) wrCycles++;
      if (p0Rd) rdCycles++;
    end else begin
      reqActive = 1'b0;
    end
    sSeen = p0Wr || p0Rd;
    sWr   = p0Wr;
    sAddr = p0Addr;
    sData = p0Data;
    sBe   = p0Be;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    applyStimulus();
    @(negedge clk);
    sampleOutputs();
  endtask

  task automatic issue(input int c, input bit wr, input bit rd, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [1:0] be);
    wantWr[c]   = wr;
    wantRd[c]   = rd;
    planAddr[c] = a;
    planData[c] = d;
    planBe[c]   = be;
    reqLeft[c]  = 1;
  endtask

  task automatic waitDone(input int c, input int tgt, input int lim, input string tag);
    int n;
    n = 0;
    while (doneCount[c] < tgt && n < lim) begin
      tick();
      n++;
    end
    checkOutput(tag, QW'(doneCount[c] >= tgt), QW'(1));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      ackCount[i] = 0; doneCount[i] = 0; ackSeen[i] = 1'b0; reqLeft[i] = 0;
      wantWr[i] = 1'b0; wantRd[i] = 1'b0; planAddr[i] = '0; planData[i] = '0; planBe[i] = '0;
    end
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      grantLog[i] = -1;
    end
    cAddr = '0; cData = '0; cBe = '0; cWr = '0; cRd = '0;
    mBusy = 1'b0; mWr = 1'b0; mCnt = 0; mReadyCyc = 0; availEarly = 1'b0;
    mAddr = '0; mData = '0; mBe = '0;
    sSeen = 1'b0; sWr = 1'b0; sAddr = '0; sData = '0; sBe = '0;
    reqActive = 1'b0; wrCycles = 0; rdCycles = 0; firstReqCyc = 0; lastAckCyc = 0; doneCyc = 0;
    reqAddr = '0; reqData = '0; reqBe = '0; qAtDone = '0;
    p0Ready = 1'b1;
    rstReq = 1'b1;
    initReq = 1'b0;
    applyStimulus();

    // Reset held: everything quiet.
    repeat (3) tick();
    checkOutput("reset_outputs", QW'({cAck, cDone, p0Wr, p0Rd, p0Addr, p0Data, p0Be}), '0);
    checkOutput("reset_cq", cQ, '0);

    // Released but controller not initialised: pending request must wait.
    rstReq = 1'b0;
    issue(0, 1'b1, 1'b0, 25'h0322020, 16'h1234, 2'b11);
    repeat (6) tick();
    checkOutput("preinit_no_ack", QW'(ackCount[0]), QW'(0));
    checkOutput("preinit_no_p0req", QW'(wrCycles + rdCycles), QW'(0));

    // Single write from client 0.
    $display("[TB] single write");
    initReq = 1'b1;
    waitDone(0, 1, 40, "t2_done");
    checkOutput("t2_ack_pulses", QW'(ackCount[0]), QW'(1));
    checkOutput("t2_wr_cycles", QW'(wrCycles), QW'(2));
    checkOutput("t2_rd_cycles", QW'(rdCycles), QW'(0));
    checkOutput("t2_addr", QW'(reqAddr), QW'(25'h0322020));
    checkOutput("t2_data", QW'(reqData), QW'(16'h1234));
    checkOutput("t2_be", QW'(reqBe), QW'(2'b11));
    checkOutput("t2_ack_to_req", QW'(firstReqCyc - lastAckCyc), QW'(1));
    checkOutput("t2_ready_to_done", QW'(doneCyc - mReadyCyc), QW'(1));

    // Eight writes spread over the clients, then a read burst by client 1.
    $display("[TB] burst fill and read");
    for (int k = 0; k < 8; k++) begin
      target = doneCount[k % 3] + 1;
      issue(k % 3, 1'b1, 1'b0, 25'h0322020 + 25'(k), words[k], 2'b11);
      waitDone(k % 3, target, 40, $sformatf("t3_wr%0d", k));
    end
    availEarly = 1'b1;
    target = doneCount[1] + 1;
    issue(1, 1'b0, 1'b1, 25'h0322020, 16'h0000, 2'b00);
    waitDone(1, target, 40, "t3_rd_done");
    checkOutput("t3_q_at_done", qAtDone, BURST_EXP);
    target = doneCount[2] + 1;
    issue(2, 1'b1, 1'b0, 25'h0000010, 16'hAAAA, 2'b11);
    waitDone(2, target, 40, "t3_wr_after_rd");
    checkOutput("t3_cq_kept_by_write", cQ, BURST_EXP);

    // All clients reading at once: strict rotation, equal service.
    $display("[TB] three-way contention");
    availEarly = 1'b0;
    gStart = grantN;
    for (int i = 0; i < N; i++) begin
      d0[i] = doneCount[i];
      wantWr[i] = 1'b0; wantRd[i] = 1'b1;
      planAddr[i] = 25'h0322020; planData[i] = '0; planBe[i] = '0;
      reqLeft[i] = 2;
    end
    budget = 0;
    sumNow = 0;
    while (sumNow < 6 && budget < 300) begin
      tick();
      budget++;
      sumNow = 0;
      for (int i = 0; i < N; i++) sumNow += doneCount[i] - d0[i];
    end
    checkOutput("t4_all_done", QW'(sumNow), QW'(6));
    for (int k = 0; k < 6; k++)
      checkOutput($sformatf("t4_order%0d", k), QW'(grantLog[gStart + k]), QW'(expOrder[k]));
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("t4_done_count%0d", i), QW'(doneCount[i] - d0[i]), QW'(2));
    checkOutput("t4_q_same_cycle", qAtDone, BURST_EXP);

    // Read and write asserted together is a write.
    $display("[TB] rd and wr together");
    wrCycles = 0;
    rdCycles = 0;
    target = doneCount[0] + 1;
    issue(0, 1'b1, 1'b1, 25'h0000005, 16'hBEEF, 2'b11);
    waitDone(0, target, 40, "t6_done");
    checkOutput("t6_rd_cycles", QW'(rdCycles), QW'(0));
    checkOutput("t6_wr_cycles", QW'(wrCycles), QW'(2));
    checkOutput("t6_data", QW'(reqData), QW'(16'hBEEF));
    checkOutput("t6_cq_kept", cQ, BURST_EXP);

    // Reset in the middle of a read's wait-for-done phase.
    $display("[TB] reset during read");
    d0[1] = doneCount[1];
    issue(1, 1'b0, 1'b1, 25'h0322020, 16'h0000, 2'b00);
    budget = 0;
    while (!mBusy && budget < 40) begin
      tick();
      budget++;
    end
    checkOutput("t5_model_busy", QW'(mBusy), QW'(1));
    tick();
    tick();
    checkOutput("t5_p0_quiet_before", QW'({p0Wr, p0Rd}), QW'(0));
    rstReq = 1'b1;
    initReq = 1'b0;
    tick();
    tick();
    checkOutput("t5_p0_after_reset", QW'({p0Wr, p0Rd, p0Addr, p0Data, p0Be}), '0);
    checkOutput("t5_cq_cleared", cQ, '0);
    rstReq = 1'b0;
    repeat (10) tick();
    checkOutput("t5_no_done", QW'(doneCount[1] - d0[1]), QW'(0));
    checkOutput("t5_cq_still_zero", cQ, '0);
    d0[0] = ackCount[0];
    d0[2] = ackCount[2];
    issue(0, 1'b0, 1'b1, 25'h0322020, 16'h0000, 2'b00);
    issue(2, 1'b0, 1'b1, 25'h0322020, 16'h0000, 2'b00);
    repeat (3) tick();
    checkOutput("t5_no_ack_preinit", QW'(ackCount[0] + ackCount[2] - d0[0] - d0[2]), QW'(0));
    gStart = grantN;
    target = doneCount[2] + 1;
    initReq = 1'b1;
    waitDone(2, target, 80, "t5_post_init_done");
    checkOutput("t5_first_grant", QW'(grantLog[gStart]), QW'(0));
    checkOutput("t5_second_grant", QW'(grantLog[gStart + 1]), QW'(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
